desc_arb: RTL and testbench

DESC_ARB -- requirements
Module: desc_arb

---
 rtl/desc_arb.sv | 198 +++++++++++++++++++
 tb/tb_desc_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/desc_arb.sv
// desc_arb -- two-requester Wishbone arbiter for a shared descriptor port.
//
// The owner's Wishbone signals pass straight through to the shared port.
// Read data and slave responses are routed back to the owner only. A
// requester keeps the port for as long as it holds cyc, so a burst is never
// split. When both requesters are waiting, the one that was not served most
// recently wins. When one owner releases the port and the other is already
// waiting, the port passes to the waiting requester with no idle cycle in
// between.
//
// Optional feature (compile-time macro DESC_ARB_TIMEOUT_EN): a stall
// watchdog. If the slave gives no response for TMO_CYC strobed cycles, the
// owner gets a one-cycle error and the port passes through S_ABORT.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no owner, shared port driven to 0
// S_OWN0  | requester 0 owns the shared port
// S_OWN1  | requester 1 owns the shared port
// S_ABORT | one-cycle recovery after a watchdog abort, port driven to 0
//
// Ports:
//   wb_clk_i, wb_rst_i          clock; synchronous active-high reset
//   mN_* (N=0,1)                requester-side Wishbone slave interfaces
//   s_*                         shared descriptor-port Wishbone master interface
//   gnt                         one-hot current owner, 2'b00 when none
//   arb_state                   debug copy of the state register
module desc_arb #(
  parameter logic [7:0] TMO_CYC = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_cab_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_dat64_i,
  output logic [31:0] m0_dat_o,
  output logic [31:0] m0_dat64_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_cab_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_dat64_i,
  output logic [31:0] m1_dat_o,
  output logic [31:0] m1_dat64_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic        s_cab_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_dat64_o,
  input  logic [31:0] s_dat_i,
  input  logic [31:0] s_dat64_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  gnt,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN0  = 2'd1,
    S_OWN1  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t state;
  logic   last;     // most recently served requester
  logic   own0;
  logic   own1;
  logic   tmo_hit;

  assign own0      = (state == S_OWN0);
  assign own1      = (state == S_OWN1);
  assign arb_state = state;

  // Shared port mux: the owner's signals pass through, and everything is 0
  // when there is no owner.
  assign s_cyc_o   = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign s_stb_o   = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign s_we_o    = (own0 & m0_we_i)  | (own1 & m1_we_i);
  assign s_cab_o   = (own0 & m0_cab_i) | (own1 & m1_cab_i);
  assign s_sel_o   = ({4{own0}} & m0_sel_i)    | ({4{own1}} & m1_sel_i);
  assign s_adr_o   = ({32{own0}} & m0_adr_i)   | ({32{own1}} & m1_adr_i);
  assign s_dat_o   = ({32{own0}} & m0_dat_i)   | ({32{own1}} & m1_dat_i);
  assign s_dat64_o = ({32{own0}} & m0_dat64_i) | ({32{own1}} & m1_dat64_i);

  // Return path: only the owner sees slave data and responses.
  assign m0_dat_o   = own0 ? s_dat_i   : 32'd0;
  assign m0_dat64_o = own0 ? s_dat64_i : 32'd0;
  assign m0_ack_o   = own0 & s_ack_i;
  assign m0_err_o   = own0 & (s_err_i | tmo_hit);
  assign m0_rty_o   = own0 & s_rty_i;
  assign m1_dat_o   = own1 ? s_dat_i   : 32'd0;
  assign m1_dat64_o = own1 ? s_dat64_i : 32'd0;
  assign m1_ack_o   = own1 & s_ack_i;
  assign m1_err_o   = own1 & (s_err_i | tmo_hit);
  assign m1_rty_o   = own1 & s_rty_i;

`ifdef DESC_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       owner_done;
  logic       s_resp;

  assign s_resp     = s_ack_i | s_err_i | s_rty_i;
  assign owner_done = (own0 & ~m0_cyc_i) | (own1 & ~m1_cyc_i);
  assign tmo_hit    = (own0 | own1) && (tmo_cnt == TMO_CYC);

  // Every ownership change out of S_OWNx goes through owner_done or tmo_hit,
  // so clearing on those, and while not owning, covers every state change.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= 8'd0;
    end else if (!(own0 | own1) || s_resp || owner_done || tmo_hit) begin
      tmo_cnt <= 8'd0;
    end else if (s_stb_o) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  // No watchdog in this build. TMO_CYC is referenced here only so that the
  // parameter is not left unused.
  assign tmo_hit = 1'b0 && (TMO_CYC == 8'd0);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      last  <= 1'b1;          // requester 0 wins the first tie
      gnt   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= S_OWN0;
            gnt   <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= S_OWN1;
            gnt   <= 2'b10;
          end
        end
        S_OWN0: begin
          if (tmo_hit) begin
            last  <= 1'b0;
            state <= S_ABORT;
            gnt   <= 2'b00;
          end else if (!m0_cyc_i) begin
            last <= 1'b0;
            if (m1_cyc_i) begin
              state <= S_OWN1;
              gnt   <= 2'b10;
            end else begin
              state <= S_IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        S_OWN1: begin
          if (tmo_hit) begin
            last  <= 1'b1;
            state <= S_ABORT;
            gnt   <= 2'b00;
          end else if (!m1_cyc_i) begin
            last <= 1'b1;
            if (m0_cyc_i) begin
              state <= S_OWN0;
              gnt   <= 2'b01;
            end else begin
              state <= S_IDLE;
              gnt   <= 2'b00;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desc_arb.sv
module tb_desc_arb;

  localparam logic [7:0] TMO = 8'd16;
`ifdef DESC_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m0_cab = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0, m0_dat64 = 0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0, m1_cab = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0, m1_dat64 = 0;
  logic [31:0] s_dat_in = 0, s_dat64_in = 0;
  logic        s_ack = 0, s_err = 0, s_rty = 0;

  logic [31:0] m0_dat_o, m0_dat64_o, m1_dat_o, m1_dat64_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_cab_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat64_o;
  logic [1:0]  gnt, arb_state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  desc_arb #(.TMO_CYC(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_cab_i(m0_cab),
    .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat64_i(m0_dat64),
    .m0_dat_o(m0_dat_o), .m0_dat64_o(m0_dat64_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_cab_i(m1_cab),
    .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat64_i(m1_dat64),
    .m1_dat_o(m1_dat_o), .m1_dat64_o(m1_dat64_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat64_o(s_dat64_o),
    .s_dat_i(s_dat_in), .s_dat64_i(s_dat64_in),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt(gnt), .arb_state(arb_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_cab = 0; m0_sel = 0; m0_adr = 0; m0_dat = 0; m0_dat64 = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_cab = 0; m1_sel = 0; m1_adr = 0; m1_dat = 0; m1_dat64 = 0;
    s_dat_in = 0; s_dat64_in = 0; s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  typedef struct {
    logic       r;
    logic       c0;
    logic       c1;
    logic [1:0] g;
  } vec_t;
  vec_t tbl[16];

  // Reference model for the random phase: owner is -1 (none), 0, 1, or 2 (aborting)
  int mown, mlast, mcnt;

  initial begin
    // Arbitration table: inputs held across one edge, expected grant after it.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'b01};  // tie after reset -> m0
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b01};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b10};  // handover without idle
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'b10};  // last was m0 -> m1 wins tie
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'b10};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 2'b01};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 2'b00};  // reset while owned
    tbl[14] = '{1'b0, 1'b1, 1'b1, 2'b01};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'b10};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].g));
      chk($sformatf("tbl%0d_state", i), 64'(arb_state),
          64'(tbl[i].g == 2'b01 ? 2'd1 : tbl[i].g == 2'b10 ? 2'd2 : 2'd0));
      chk($sformatf("tbl%0d_scyc", i), 64'(s_cyc_o),
          64'((tbl[i].g[0] & tbl[i].c0) | (tbl[i].g[1] & tbl[i].c1)));
    end
    rst = 0;

    // m0 runs a 4-beat burst read alone
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_cab = 1; m0_sel = 4'hf; m0_adr = 32'h100;
    @(posedge clk); #1;
    chk("burst_gnt", 64'(gnt), 64'(2'b01));
    for (int b = 0; b < 4; b++) begin
      m0_adr = 32'h100 + 32'(4 * b);
      s_ack = 1; s_dat_in = 32'ha0 + 32'(b); s_dat64_in = 32'hb0 + 32'(b);
      #1;
      chk($sformatf("burst%0d_adr", b), 64'(s_adr_o), 64'(32'h100 + 32'(4 * b)));
      chk($sformatf("burst%0d_cab", b), 64'(s_cab_o), 64'(1'b1));
      chk($sformatf("burst%0d_ack", b), 64'({m0_ack_o, m1_ack_o}), 64'(2'b10));
      chk($sformatf("burst%0d_dat", b), {m0_dat64_o, m0_dat_o}, {32'hb0 + 32'(b), 32'ha0 + 32'(b)});
      chk($sformatf("burst%0d_m1dat", b), {m1_dat64_o, m1_dat_o}, 64'd0);
      @(posedge clk); #1;
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_cab = 0;
    @(posedge clk); #1;
    chk("burst_release_gnt", 64'(gnt), 64'(2'b00));

    // Reset during beat 2 of an m1 burst
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_cab = 1; m1_adr = 32'h200;
    @(posedge clk); #1;
    chk("rstmid_gnt1", 64'(gnt), 64'(2'b10));
    s_ack = 1;
    @(posedge clk); #1;
    m1_adr = 32'h204;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rstmid_scyc", 64'(s_cyc_o), 64'(1'b0));
    chk("rstmid_gnt", 64'(gnt), 64'(2'b00));
    chk("rstmid_state", 64'(arb_state), 64'(2'd0));
    chk("rstmid_resp", 64'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 64'd0);
    s_ack = 0; m0_cyc = 1; m0_stb = 1;
    @(posedge clk); #1;
    chk("rstmid_after_gnt", 64'(gnt), 64'(2'b01));

    // Stalled slave with m1 pending
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    begin
      int err_n, err_at, abort_n, m1_at, not01;
      err_n = 0; err_at = -1; abort_n = 0; m1_at = -1; not01 = 0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (m0_err_o) begin err_n++; if (err_at < 0) err_at = k; end
        if (arb_state == 2'd3) begin
          abort_n++;
          chk("stall_abort_scyc", 64'(s_cyc_o), 64'(1'b0));
        end
        if (gnt == 2'b10 && m1_at < 0) m1_at = k;
        if (gnt != 2'b01) not01++;
      end
      if (TMO_EN) begin
        chk("stall_err_pulses", 64'(err_n), 64'd1);
        chk("stall_err_cycle", 64'(err_at), 64'(32'(TMO) + 1));
        chk("stall_abort_cycles", 64'(abort_n), 64'd1);
        chk("stall_m1_grant_cycle", 64'(m1_at), 64'(32'(TMO) + 4));
      end else begin
        chk("stall_err_pulses", 64'(err_n), 64'd0);
        chk("stall_gnt_not01", 64'(not01), 64'd0);
      end
    end

    // Randomized traffic against the reference model
    do_reset();
    mown = -1; mlast = 1; mcnt = 0;
    for (int it = 0; it < 500; it++) begin
      logic        e_cyc, e_stb, e_we, e_cab, hit, resp;
      logic [3:0]  e_sel;
      logic [31:0] e_adr, e_dat, e_dat64;
      logic [1:0]  e_gnt, e_state;
      int          nown;
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = 1'($urandom); m0_we = 1'($urandom); m0_cab = 1'($urandom); m0_sel = 4'($urandom);
      m1_stb = 1'($urandom); m1_we = 1'($urandom); m1_cab = 1'($urandom); m1_sel = 4'($urandom);
      m0_adr = $urandom; m0_dat = $urandom; m0_dat64 = $urandom;
      m1_adr = $urandom; m1_dat = $urandom; m1_dat64 = $urandom;
      s_dat_in = $urandom; s_dat64_in = $urandom;
      s_ack = ($urandom_range(5) == 0); s_err = ($urandom_range(15) == 0); s_rty = ($urandom_range(15) == 0);
      #2;
      if (mown == 0) begin
        {e_cyc, e_stb, e_we, e_cab, e_sel} = {m0_cyc, m0_stb, m0_we, m0_cab, m0_sel};
        {e_adr, e_dat, e_dat64} = {m0_adr, m0_dat, m0_dat64};
      end else if (mown == 1) begin
        {e_cyc, e_stb, e_we, e_cab, e_sel} = {m1_cyc, m1_stb, m1_we, m1_cab, m1_sel};
        {e_adr, e_dat, e_dat64} = {m1_adr, m1_dat, m1_dat64};
      end else begin
        {e_cyc, e_stb, e_we, e_cab, e_sel} = '0;
        {e_adr, e_dat, e_dat64} = '0;
      end
      hit   = TMO_EN && (mown == 0 || mown == 1) && (mcnt == int'(TMO));
      resp  = s_ack | s_err | s_rty;
      e_gnt = (mown == 0) ? 2'b01 : (mown == 1) ? 2'b10 : 2'b00;
      e_state = (mown == 0) ? 2'd1 : (mown == 1) ? 2'd2 : (mown == 2) ? 2'd3 : 2'd0;
      chk("rnd_gnt", 64'(gnt), 64'(e_gnt));
      chk("rnd_state", 64'(arb_state), 64'(e_state));
      chk("rnd_sctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_sel_o}), 64'({e_cyc, e_stb, e_we, e_cab, e_sel}));
      chk("rnd_sadr", 64'(s_adr_o), 64'(e_adr));
      chk("rnd_sdat", {s_dat64_o, s_dat_o}, {e_dat64, e_dat});
      chk("rnd_m0resp", 64'({m0_ack_o, m0_err_o, m0_rty_o}),
          64'(mown == 0 ? {s_ack, s_err | hit, s_rty} : 3'b000));
      chk("rnd_m1resp", 64'({m1_ack_o, m1_err_o, m1_rty_o}),
          64'(mown == 1 ? {s_ack, s_err | hit, s_rty} : 3'b000));
      chk("rnd_m0dat", {m0_dat64_o, m0_dat_o}, (mown == 0) ? {s_dat64_in, s_dat_in} : 64'd0);
      chk("rnd_m1dat", {m1_dat64_o, m1_dat_o}, (mown == 1) ? {s_dat64_in, s_dat_in} : 64'd0);

      nown = mown;
      if (rst) begin
        nown = -1; mlast = 1; mcnt = 0;
      end else begin
        if (mown == -1) begin
          if (m0_cyc && m1_cyc) nown = (mlast == 1) ? 0 : 1;
          else if (m0_cyc) nown = 0;
          else if (m1_cyc) nown = 1;
        end else if (mown == 2) begin
          nown = -1;
        end else begin
          logic mine, other;
          mine  = (mown == 0) ? m0_cyc : m1_cyc;
          other = (mown == 0) ? m1_cyc : m0_cyc;
          if (hit) begin
            mlast = mown; nown = 2;
          end else if (!mine) begin
            mlast = mown; nown = other ? 1 - mown : -1;
          end
        end
        if (!(mown == 0 || mown == 1) || nown != mown || resp) mcnt = 0;
        else if (e_stb) mcnt = mcnt + 1;
      end
      mown = nown;
      @(posedge clk); #1;
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
